sdram_init_seq: RTL
===================

// Module: sdram_init_seq
// PURPOSE
//  Power-up initialisation sequencer for the SDR SDRAM controller (MT48LC2M32B2 class: 11-bit row, 8-bit col, 4 banks, x32).
//  Runs once after reset: power-up wait, PRECHARGE ALL, REF_COUNT x AUTO REFRESH, LOAD MODE REGISTER; then raises init_done.
//  Upstream of the auto-refresh/command stage: ctrl top muxes this block's command bus onto the sdr_* pins while init_done=0.
// PARAMETERS
//  CLK_MHZ       100  controller clock frequency, MHz
//  T_POWERUP_US  200  power-up NOP wait, us (POWERUP_CYC = T_POWERUP_US*CLK_MHZ)
//  T_RP          2    PRECHARGE-to-next-command, cycles (>=1)
//  T_RFC         7    AUTO REFRESH-to-next-command, cycles (>=1)
//  T_MRD         2    LOAD MODE-to-init_done, cycles (>=1)
//  REF_COUNT     8    number of AUTO REFRESH commands (>=1)
//  CAS_LAT       3    CAS latency written to mode register (2 or 3)
//  BURST_CODE    3'b000  mode A[2:0] burst length (000 = BL1)
//  ADDR_W        11   sdr_addr width;  BA_W  2  sdr_ba width
// PORTS
//  clk        in   1       controller clock
//  rst        in   1       synchronous reset, active-high
//  sdr_cke    out  1       clock enable
//  sdr_csn    out  1       chip select, active-low
//  sdr_rasn   out  1       RAS, active-low
//  sdr_casn   out  1       CAS, active-low
//  sdr_wen    out  1       WE, active-low
//  sdr_addr   out  ADDR_W  address (A10 = all-banks on PRECHARGE; mode word on LMR)
//  sdr_ba     out  BA_W    bank address
//  init_done  out  1       sequence complete; sticky until rst
// BEHAVIOUR
//  - All outputs registered. Reset values: cke=0, {csn,rasn,casn,wen}=NOP 4'b0111, addr=0, ba=0, init_done=0.
//  - Commands {csn,rasn,casn,wen}: NOP 0111, PRECHARGE 0010, AUTO REFRESH 0001, LOAD MODE 0000. Each non-NOP lasts exactly 1 cycle.
//  - FSM: S_WAIT -> S_PRE -> S_TRP -> S_REF -> S_TRFC -> (S_REF | S_MRS) -> S_TMRD -> S_DONE.
//    S_WAIT: cke=1 from first cycle after rst low; NOP for POWERUP_CYC cycles.
//    S_PRE: PRECHARGE, addr[10]=1, ba=0. S_TRP: NOP until next command lands exactly T_RP cycles after PRECHARGE.
//    S_REF: AUTO REFRESH, ref_cnt++. S_TRFC: NOP; next cmd exactly T_RFC cycles later; REF again if ref_cnt<REF_COUNT, else S_MRS.
//    S_MRS: LOAD MODE, ba=0, addr = {1'b0(A10), 1'b0(A9 burst write), 2'b00, CAS_LAT[2:0], 1'b0(seq), BURST_CODE}.
//    S_TMRD: NOP; init_done=1 exactly T_MRD cycles after LOAD MODE. S_DONE: NOP, cke=1, init_done=1, terminal.
//  - Timing: first PRECHARGE on outputs exactly POWERUP_CYC cycles after first cycle with rst=0.
//  - Counters: one shared down-counter, width $clog2(POWERUP_CYC+1); ref_cnt width $clog2(REF_COUNT+1). No wrap possible.
//  - rst mid-sequence or after done: next cycle returns all outputs to reset values and restarts from S_WAIT with full wait.
//  - addr/ba are don't-care-free: driven 0 on every NOP cycle.
// CONFIGURATION
//  SDR_INIT_SIM_FAST_EN defined: POWERUP_CYC forced to 16 regardless of T_POWERUP_US/CLK_MHZ (simulation only).
//  Not defined: POWERUP_CYC = T_POWERUP_US*CLK_MHZ (20000 at defaults). Rest of sequence identical either way.
// STRUCTURE
//  sdram_pkg: sdr_cmd_t enum (CMD_NOP/CMD_PRE/CMD_REF/CMD_LMR, 4-bit {csn,rasn,casn,wen}),
//   init_state_t enum, function mode_word(cas_lat, burst_code) -> 11-bit LMR word, default timing localparams.
//  Sub-module: sdram_delay_cnt (load value, dec, zero flag), reused later by the refresh timer.
// TESTING
//  1 SIM_FAST, defaults, rst high 5 cycles then low -> cke=1 at cycle 1; PRECHARGE with addr[10]=1 at cycle 16.
//  2 Same run -> 8 AUTO REFRESH at cycles 18,25,...,67; LOAD MODE at 74 with addr=11'h030; init_done=1 at 76, stays 1.
//  3 CAS_LAT=2, BURST_CODE=3'b011 -> LMR addr=11'h023; sdram_model_plus reports mode CL2 BL8 with no timing warnings.
//  4 rst pulsed 1 cycle at cycle 40 (mid-refresh) -> next cycle NOP, cke=0, init_done=0; PRECHARGE again 16 cycles after rst low.
//  5 REF_COUNT=1, T_RFC=1, T_RP=1 -> PRE@16, REF@17, LMR@18, init_done@20; never two non-NOP cmds adjacent below tXX.
//  6 No SIM_FAST, defaults -> first PRECHARGE at cycle 20000 (200 us at 100 MHz); no non-NOP command before it.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDR SDRAM command encodings, init FSM states, mode word helper, default timings
package sdram_pkg;
  typedef enum logic [3:0] {
    CMD_NOP = 4'b0111,
    CMD_PRE = 4'b0010,
    CMD_REF = 4'b0001,
    CMD_LMR = 4'b0000
  } sdr_cmd_t;
  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_REF, S_TRFC, S_MRS, S_TMRD, S_DONE
  } init_state_t;
  localparam int CLK_MHZ_DEF      = 100;
  localparam int T_POWERUP_US_DEF = 200;
  localparam int T_RP_DEF         = 2;
  localparam int T_RFC_DEF        = 7;
  localparam int T_MRD_DEF        = 2;
  localparam int REF_COUNT_DEF    = 8;
  localparam int CAS_LAT_DEF      = 3;
  // A10=0, A9=0 (burst write), A8:7=00, A6:4=CL, A3=0 (sequential), A2:0=burst length
  function automatic logic [10:0] mode_word(input logic [2:0] cas_lat, input logic [2:0] burst_code);
    return {1'b0, 1'b0, 2'b00, cas_lat, 1'b0, burst_code};
  endfunction
endpackage

// File: rtl/sdram_delay_cnt.sv
// sdram_delay_cnt: loadable down-counter that holds at zero
//   clk, rst  : clock, sync active-high reset (counter takes RST_VAL)
//   i_load    : load i_val (wins over i_dec)
//   i_val     : value to load
//   i_dec     : decrement when not already zero
//   o_zero    : count is zero
module sdram_delay_cnt #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= RST_VAL;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: one-shot SDR SDRAM power-up sequence (wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE)
//   clk, rst                        : clock, sync active-high reset (restarts the whole sequence)
//   sdr_cke                         : clock enable, 1 from the first cycle out of reset
//   sdr_csn/rasn/casn/wen           : command bus, one registered cycle per non-NOP command
//   sdr_addr, sdr_ba                : address/bank, zero except on PRECHARGE (A10) and LOAD MODE
//   init_done                       : sticky completion flag
//   Macro SDR_INIT_SIM_FAST_EN shortens the power-up wait to 16 cycles for simulation.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int          CLK_MHZ      = CLK_MHZ_DEF,
  parameter int          T_POWERUP_US = T_POWERUP_US_DEF,
  parameter int          T_RP         = T_RP_DEF,
  parameter int          T_RFC        = T_RFC_DEF,
  parameter int          T_MRD        = T_MRD_DEF,
  parameter int          REF_COUNT    = REF_COUNT_DEF,
  parameter int          CAS_LAT      = CAS_LAT_DEF,
  parameter logic [2:0]  BURST_CODE   = 3'b000,
  parameter int          ADDR_W       = 11,
  parameter int          BA_W         = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              sdr_cke,
  output logic              sdr_csn,
  output logic              sdr_rasn,
  output logic              sdr_casn,
  output logic              sdr_wen,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [BA_W-1:0]   sdr_ba,
  output logic              init_done
);
`ifdef SDR_INIT_SIM_FAST_EN
  localparam int POWERUP_CYC = 16;
`else
  localparam int POWERUP_CYC = T_POWERUP_US * CLK_MHZ;
`endif
  localparam int CW = $clog2(POWERUP_CYC + 1);
  localparam int RW = $clog2(REF_COUNT + 1);
  init_state_t       r_state, w_next;
  sdr_cmd_t          r_cmd, w_cmd;
  logic [RW-1:0]     r_ref_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [CW-1:0]     w_load_val;
  logic              r_cke, r_done, w_zero, w_load, w_last_ref;
  // Each command state loads T-1 and counts down alongside the following NOP
  // state, so a timing of 1 skips the NOP state entirely.
  sdram_delay_cnt #(.W(CW), .RST_VAL(CW'(POWERUP_CYC - 1))) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .i_dec  (1'b1),
    .o_zero (w_zero)
  );
  always_comb begin
    w_next     = r_state;
    w_last_ref = r_ref_cnt == RW'(REF_COUNT);
    case (r_state)
      S_WAIT:         w_next = w_zero ? S_PRE : S_WAIT;
      S_PRE, S_TRP:   w_next = w_zero ? S_REF : S_TRP;
      S_REF, S_TRFC:  w_next = w_zero ? (w_last_ref ? S_MRS : S_REF) : S_TRFC;
      S_MRS, S_TMRD:  w_next = w_zero ? S_DONE : S_TMRD;
      default:        w_next = S_DONE;
    endcase
    w_cmd      = w_next == S_PRE ? CMD_PRE : w_next == S_REF ? CMD_REF : w_next == S_MRS ? CMD_LMR : CMD_NOP;
    w_addr     = w_next == S_PRE ? ADDR_W'(11'h400) :
                 w_next == S_MRS ? ADDR_W'(mode_word(3'(CAS_LAT), BURST_CODE)) : '0;
    w_load     = w_next == S_PRE || w_next == S_REF || w_next == S_MRS;
    w_load_val = w_next == S_PRE ? CW'(T_RP - 1) : w_next == S_REF ? CW'(T_RFC - 1) : CW'(T_MRD - 1);
  end
  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= S_WAIT;
      r_ref_cnt <= '0;
      r_cke     <= 1'b0;
      r_cmd     <= CMD_NOP;
      r_addr    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ref_cnt <= w_next == S_REF ? r_ref_cnt + RW'(1) : r_ref_cnt;
      r_cke     <= 1'b1;
      r_cmd     <= w_cmd;
      r_addr    <= w_addr;
      r_done    <= w_next == S_DONE;
    end
  assign sdr_cke                               = r_cke;
  assign {sdr_csn, sdr_rasn, sdr_casn, sdr_wen} = r_cmd;
  assign sdr_addr                              = r_addr;
  assign sdr_ba                                = '0;
  assign init_done                             = r_done;
endmodule
